axis_frame_sink: RTL and testbench

//  AXI4-Stream frame receiver/checker for the XGS image path's 64-bit tx stream (tdata/tuser/tlast).

---
 rtl/axis_frame_sink.sv | 151 +++++++++++++++
 tb/tb_axis_frame_sink.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_sink.sv
// AXI4-Stream frame sink: programmable tready backpressure,
// SOF/SOL/EOL/EOF framing checks, line/frame measurement and checksum.
module axis_frame_sink #(
  parameter int DATA_WIDTH = 64,
  parameter int USER_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aclk_reset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  input  logic [15:0]           bp_pattern,
  input  logic                  bp_enable,
  input  logic                  clr_status,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  line_beats,
  output logic [CNT_WIDTH-1:0]  frame_lines,
  output logic [31:0]           frame_csum,
  output logic [3:0]            err_flags
);

  localparam int LANES = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LINE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state;

  logic [15:0] rot;
  logic        started;
  logic        bp_q;
  logic        tready_q;

  assign s_axis_tready = tready_q;

  // Rotator is (re)loaded so that pattern bit 0 governs the next cycle.
  always_ff @(posedge aclk or posedge aclk_reset) begin
    if (aclk_reset) begin
      rot      <= '0;
      started  <= 1'b0;
      bp_q     <= 1'b0;
      tready_q <= 1'b0;
    end else begin
      bp_q <= bp_enable;
      if (!started) begin
        started <= 1'b1;
        rot     <= bp_pattern;
      end else if (bp_enable && !bp_q) begin
        rot      <= {bp_pattern[0], bp_pattern[15:1]};
        tready_q <= bp_pattern[0];
      end else begin
        rot      <= {rot[0], rot[15:1]};
        tready_q <= bp_enable ? rot[0] : 1'b1;
      end
    end
  end

  logic [31:0] beat_sum;

  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_sum = beat_sum + s_axis_tdata[i*32 +: 32];
    end
  end

  logic sof, eof, sol, eol;
  logic acc, abort, start, drop, cont, take;
  logic line_end, frame_end, first_line;
  logic len_err, order_err, tlast_err;

  logic [CNT_WIDTH-1:0] beat;
  logic [CNT_WIDTH-1:0] lines;
  logic [CNT_WIDTH-1:0] ref_len;
  logic [CNT_WIDTH-1:0] beat_cur;
  logic [CNT_WIDTH-1:0] lines_base;
  logic [CNT_WIDTH-1:0] ref_cur;
  logic [31:0]          csum;
  logic [31:0]          csum_cur;

  assign sof = s_axis_tuser[0];
  assign eof = s_axis_tuser[1];
  assign sol = s_axis_tuser[2];
  assign eol = s_axis_tuser[3];

  assign acc   = s_axis_tvalid && tready_q;
  assign abort = acc && sof && (state != IDLE);
  assign start = acc && ((state == IDLE && sof && sol) || abort);
  assign drop  = acc && (state == IDLE) && !(sof && sol);
  assign cont  = acc && (state != IDLE) && !sof;
  assign take  = start || cont;

  // A beat arriving in GAP always opens a new line, SOL or not.
  assign beat_cur   = (start || state == GAP) ? CNT_WIDTH'(1)
                                              : beat + CNT_WIDTH'(1);
  assign csum_cur   = (start ? 32'd0 : csum) + beat_sum;
  assign lines_base = start ? '0 : lines;
  assign first_line = (lines_base == '0);
  assign ref_cur    = first_line ? beat_cur : ref_len;

  assign line_end  = take && eol;
  assign frame_end = line_end && eof;
  assign len_err   = line_end && !first_line && (beat_cur != ref_len);
  assign order_err = drop || (cont && state == GAP && !sol)
                          || (take && eof && !eol);
  assign tlast_err = acc && (s_axis_tlast != eol);

  always_ff @(posedge aclk or posedge aclk_reset) begin
    if (aclk_reset) begin
      state       <= IDLE;
      beat        <= '0;
      lines       <= '0;
      ref_len     <= '0;
      csum        <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      line_beats  <= '0;
      frame_lines <= '0;
      frame_csum  <= '0;
      err_flags   <= '0;
    end else begin
      frame_done <= frame_end;
      frame_cnt  <= (clr_status ? '0 : frame_cnt)
                    + CNT_WIDTH'(frame_end);
      err_flags  <= (clr_status ? 4'b0 : err_flags)
                    | {abort, tlast_err, len_err, order_err};
      if (take) begin
        beat  <= beat_cur;
        csum  <= csum_cur;
        lines <= line_end ? lines_base + CNT_WIDTH'(1) : lines_base;
        if (line_end) ref_len <= ref_cur;
        if (frame_end)     state <= IDLE;
        else if (line_end) state <= GAP;
        else               state <= LINE;
      end
      if (frame_end) begin
        frame_lines <= lines_base + CNT_WIDTH'(1);
        line_beats  <= ref_cur;
        frame_csum  <= csum_cur;
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_sink.sv
// Bench for axis_frame_sink: directed frame table, corner sequences,
// and random frames checked against a frame-level reference model.
module tb_axis_frame_sink;

  logic        aclk = 1'b0;
  logic        aclk_reset = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tuser = '0;
  logic        s_axis_tlast = 1'b0;
  logic [15:0] bp_pattern = 16'hFFFF;
  logic        bp_enable = 1'b0;
  logic        clr_status = 1'b0;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic [15:0] line_beats;
  logic [15:0] frame_lines;
  logic [31:0] frame_csum;
  logic [3:0]  err_flags;

  axis_frame_sink dut (
    .aclk          (aclk),
    .aclk_reset    (aclk_reset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .bp_pattern    (bp_pattern),
    .bp_enable     (bp_enable),
    .clr_status    (clr_status),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .line_beats    (line_beats),
    .frame_lines   (frame_lines),
    .frame_csum    (frame_csum),
    .err_flags     (err_flags)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: frames as lists of line lengths.
  bit          m_in;
  bit          m_gap;
  int          m_lens[$];
  int          m_cur;
  logic [31:0] m_csum;
  logic [3:0]  e_err;
  logic [15:0] e_cnt;
  logic [15:0] e_lines;
  logic [15:0] e_beats;
  logic [31:0] e_csum;
  bit          e_done;

  task automatic model_reset();
    m_in = 0; m_gap = 0; m_lens.delete(); m_cur = 0; m_csum = 0;
    e_err = 0; e_cnt = 0; e_lines = 0; e_beats = 0; e_csum = 0;
    e_done = 0;
  endtask

  task automatic model_beat(input logic [63:0] d, input logic [3:0] u,
                            input logic l);
    logic [31:0] s;
    s = d[31:0] + d[63:32];
    e_done = 0;
    if (l != u[3]) e_err[2] = 1'b1;
    if (!m_in && !(u[0] && u[2])) begin
      e_err[0] = 1'b1;
      return;
    end
    if (!m_in || u[0]) begin
      if (m_in) e_err[3] = 1'b1;
      m_lens.delete(); m_csum = s; m_cur = 1; m_gap = 0; m_in = 1;
    end else begin
      if (m_gap) begin
        if (!u[2]) e_err[0] = 1'b1;
        m_cur = 0; m_gap = 0;
      end
      m_cur++;
      m_csum += s;
    end
    if (u[1] && !u[3]) e_err[0] = 1'b1;
    if (u[3]) begin
      if (m_lens.size() > 0 && m_cur != m_lens[0]) e_err[1] = 1'b1;
      m_lens.push_back(m_cur);
      m_gap = 1;
      if (u[1]) begin
        m_in = 0;
        e_lines = 16'(m_lens.size());
        e_beats = 16'(m_lens[0]);
        e_csum = m_csum;
        e_cnt++;
        e_done = 1;
      end
    end
  endtask

  task automatic send(input logic [63:0] d, input logic [3:0] u,
                      input logic l);
    int  w;
    bit  ok;
    w = 0; ok = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d;
    s_axis_tuser = u; s_axis_tlast = l;
    while (w <= 40) begin
      @(negedge aclk);
      if (s_axis_tready) begin ok = 1; break; end
      w++;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL tready_timeout: got 0 expected 1");
      s_axis_tvalid = 1'b0;
      return;
    end
    model_beat(d, u, l);
    @(posedge aclk); #1;
    s_axis_tvalid = 1'b0;
    chk("frame_done", 64'(frame_done), 64'(e_done));
    chk("err_flags", 64'(err_flags), 64'(e_err));
    if (e_done) begin
      chk("frame_lines", 64'(frame_lines), 64'(e_lines));
      chk("line_beats", 64'(line_beats), 64'(e_beats));
      chk("frame_csum", 64'(frame_csum), 64'(e_csum));
      chk("frame_cnt", 64'(frame_cnt), 64'(e_cnt));
    end
  endtask

  task automatic send_frame(input int nl, input int nb, input int sl,
                            input int sn, input int sof_l, input int sof_b,
                            input int bad_l, input bit rnd);
    int          idx;
    int          len;
    logic [3:0]  u;
    logic [63:0] d;
    idx = 0;
    for (int li = 0; li < nl; li++) begin
      len = (li == sl) ? sn : nb;
      for (int b = 0; b < len; b++) begin
        u[0] = (li == 0 && b == 0) || (li == sof_l && b == sof_b);
        u[2] = (b == 0);
        u[3] = (b == len - 1);
        u[1] = u[3] && (li == nl - 1);
        d = rnd ? {$urandom, $urandom} : 64'(idx);
        send(d, u, u[3] && (li != bad_l));
        idx++;
      end
    end
  endtask

  task automatic clr_pulse();
    clr_status = 1'b1;
    @(posedge aclk); #1;
    clr_status = 1'b0;
    e_err = 0; e_cnt = 0;
  endtask

  typedef struct {
    int          nl, nb, sl, sn, sof_l, sof_b, bad_l;
    bit          bp;
    logic [15:0] pat;
    bit          tog;
    int          cyc_lo, cyc_hi;
    int          x_lines, x_beats;
    logic [3:0]  x_err;
    logic [31:0] x_csum;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int p;
    int c0;
    int nl, nb, sl, sn, sfl, bl;
    // nl nb sl sn sofl sofb badl bp pat tog cyclo cychi lines beats err csum
    tbl[0] = '{4, 8, -1, 0, -1, -1, -1, 0, 16'hFFFF, 0, 32, 32,
               4, 8, 4'b0000, 32'd496};
    tbl[1] = '{4, 8, -1, 0, -1, -1, -1, 1, 16'hAAAA, 1, 63, 64,
               4, 8, 4'b0000, 32'd496};
    tbl[2] = '{4, 8, 2, 7, -1, -1, -1, 0, 16'hFFFF, 0, 0, 0,
               4, 8, 4'b0010, 32'd465};
    tbl[3] = '{4, 8, -1, 0, 1, 2, -1, 0, 16'hFFFF, 0, 0, 0,
               3, 6, 4'b1010, 32'd451};
    tbl[4] = '{1, 1, -1, 0, -1, -1, -1, 0, 16'hFFFF, 0, 0, 0,
               1, 1, 4'b0000, 32'd0};
    tbl[5] = '{2, 3, -1, 0, -1, -1, -1, 1, 16'h0F0F, 0, 0, 0,
               2, 3, 4'b0000, 32'd15};
    tbl[6] = '{4, 8, -1, 0, -1, -1, 0, 0, 16'hFFFF, 0, 0, 0,
               4, 8, 4'b0100, 32'd496};

    model_reset();
    #12;
    chk("rst_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_done", 64'(frame_done), 64'd0);
    chk("rst_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_err", 64'(err_flags), 64'd0);
    chk("rst_csum", 64'(frame_csum), 64'd0);
    @(posedge aclk); #1;
    aclk_reset = 1'b0;
    @(negedge aclk);
    chk("tready_first", 64'(s_axis_tready), 64'd0);
    repeat (3) @(posedge aclk);
    #1;
    chk("tready_nobp", 64'(s_axis_tready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      bp_pattern = tbl[i].pat;
      bp_enable = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      clr_pulse();
      bp_enable = tbl[i].bp;
      repeat (3) @(posedge aclk);
      #1;
      if (tbl[i].tog) begin
        for (int k = 0; k < 8; k++) begin
          @(negedge aclk); p = s_axis_tready;
          @(negedge aclk);
          chk("tready_toggle", 64'(s_axis_tready), 64'(!p));
        end
        @(posedge aclk); #1;
      end
      c0 = cyc;
      send_frame(tbl[i].nl, tbl[i].nb, tbl[i].sl, tbl[i].sn,
                 tbl[i].sof_l, tbl[i].sof_b, tbl[i].bad_l, 0);
      if (tbl[i].cyc_hi > 0)
        chk("frame_cycles", 64'(cyc - c0 >= tbl[i].cyc_lo &&
                                cyc - c0 <= tbl[i].cyc_hi), 64'd1);
      chk("tbl_lines", 64'(frame_lines), 64'(tbl[i].x_lines));
      chk("tbl_beats", 64'(line_beats), 64'(tbl[i].x_beats));
      chk("tbl_err", 64'(err_flags), 64'(tbl[i].x_err));
      chk("tbl_csum", 64'(frame_csum), 64'(tbl[i].x_csum));
      chk("tbl_cnt", 64'(frame_cnt), 64'd1);
    end

    clr_pulse();
    chk("clr_err", 64'(err_flags), 64'd0);
    chk("clr_cnt", 64'(frame_cnt), 64'd0);

    // Reset in the middle of line 2, then a clean 2x4 frame.
    bp_enable = 1'b0;
    for (int b = 0; b < 11; b++)
      send(64'(b), {(b % 8) == 7, 1'b0, (b % 8) == 0, b == 0},
           (b % 8) == 7);
    #2;
    aclk_reset = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_tready", 64'(s_axis_tready), 64'd0);
    chk("mid_rst_lines", 64'(frame_lines), 64'd0);
    chk("mid_rst_beats", 64'(line_beats), 64'd0);
    chk("mid_rst_csum", 64'(frame_csum), 64'd0);
    chk("mid_rst_err", 64'(err_flags), 64'd0);
    repeat (2) @(posedge aclk);
    #1;
    aclk_reset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    send_frame(2, 4, -1, 0, -1, -1, -1, 1);
    chk("t6_lines", 64'(frame_lines), 64'd2);
    chk("t6_beats", 64'(line_beats), 64'd4);
    chk("t6_cnt", 64'(frame_cnt), 64'd1);
    chk("t6_err", 64'(err_flags), 64'd0);

    // Random frames with random backpressure and occasional faults.
    for (int r = 0; r < 24; r++) begin
      bp_pattern = 16'($urandom) | 16'h0001;
      bp_enable = 1'($urandom);
      nl = $urandom_range(1, 4);
      nb = $urandom_range(1, 6);
      sl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
      sn = $urandom_range(1, nb);
      sfl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nl - 1) : -1;
      bl = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nl - 1) : -1;
      if ($urandom_range(0, 6) == 0)
        send({$urandom, $urandom}, 4'($urandom_range(0, 15)) & 4'b1110,
             1'($urandom));
      if ($urandom_range(0, 4) == 0) clr_pulse();
      send_frame(nl, nb, sl, sn, sfl, $urandom_range(0, nb - 1), bl, 1);
      chk("rnd_cnt", 64'(frame_cnt), 64'(e_cnt));
      chk("rnd_err", 64'(err_flags), 64'(e_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
